// File: rtl/count_bcd_7seg_if.sv
// Display-stage bus: binary count in, packed BCD digits, segment codes and status out.
interface count_bcd_7seg_if;
    logic [7:0]  count;
    logic [11:0] bcd;
    logic [6:0]  hex2;
    logic [6:0]  hex1;
    logic [6:0]  hex0;
    logic        busy;
    logic        done;

    // Up-counter side: drives the value, observes the display.
    modport master (
        output count,
        input  bcd, hex2, hex1, hex0, busy, done
    );

    // Display stage side.
    modport slave (
        input  count,
        output bcd, hex2, hex1, hex0, busy, done
    );
endinterface

// File: rtl/count_bcd_7seg.sv
// Binary-to-BCD display stage: sequential shift-and-add-3 conversion driving
// three seven-segment digits with optional leading-zero blanking.
module count_bcd_7seg #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic              clk50m,
    input  logic              rst,
    count_bcd_7seg_if.slave   disp
);

    localparam int unsigned VAL_W  = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned ITER_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Segment pattern for one digit in gfedcba order, honouring output polarity.
    function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] digit, input logic blank);
        logic [SEG_W-1:0] code;
        code = 7'b1111111;
        if (!blank) begin
            case (digit)
                4'd0:    code = 7'b1000000;
                4'd1:    code = 7'b1111001;
                4'd2:    code = 7'b0100100;
                4'd3:    code = 7'b0110000;
                4'd4:    code = 7'b0011001;
                4'd5:    code = 7'b0010010;
                4'd6:    code = 7'b0000010;
                4'd7:    code = 7'b1111000;
                4'd8:    code = 7'b0000000;
                4'd9:    code = 7'b0010000;
                default: code = 7'b1111111;
            endcase
        end
        return SEG_ACTIVE_LOW ? code : ~code;
    endfunction

    state_t             state_q,   state_d;
    logic [VAL_W-1:0]   val_q,     val_d;
    logic [VAL_W-1:0]   sh_q,      sh_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [ITER_W-1:0]  iter_q,    iter_d;
    logic [VAL_W-1:0]   shown_q,   shown_d;
    logic [BCD_W-1:0]   bcd_q,     bcd_d;
    logic [SEG_W-1:0]   hex2_q,    hex2_d;
    logic [SEG_W-1:0]   hex1_q,    hex1_d;
    logic [SEG_W-1:0]   hex0_q,    hex0_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [BCD_W-1:0]       adj;
    logic [BCD_W+VAL_W-1:0] shifted;

    // Add-3 correction of every scratch digit that is 5 or more.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
        shifted = {adj, sh_q} << 1;
    end

    // Next-state and output computation.
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        sh_d      = sh_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        shown_d   = shown_q;
        bcd_d     = bcd_q;
        hex2_d    = hex2_q;
        hex1_d    = hex1_q;
        hex0_d    = hex0_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (disp.count != shown_q) begin
                    val_d     = disp.count;
                    sh_d      = disp.count;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = shifted[BCD_W+VAL_W-1:VAL_W];
                sh_d      = shifted[VAL_W-1:0];
                iter_d    = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(7)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                bcd_d   = scratch_q;
                hex2_d  = seg_code(scratch_q[11:8],
                                   BLANK_LEADING && (scratch_q[11:8] == 4'd0));
                hex1_d  = seg_code(scratch_q[7:4],
                                   BLANK_LEADING && (scratch_q[11:4] == 8'd0));
                hex0_d  = seg_code(scratch_q[3:0], 1'b0);
                shown_d = val_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            state_q   <= IDLE;
            val_q     <= '0;
            sh_q      <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            shown_q   <= '0;
            bcd_q     <= '0;
            hex2_q    <= seg_code(4'd0, BLANK_LEADING);
            hex1_q    <= seg_code(4'd0, BLANK_LEADING);
            hex0_q    <= seg_code(4'd0, 1'b0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            sh_q      <= sh_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            shown_q   <= shown_d;
            bcd_q     <= bcd_d;
            hex2_q    <= hex2_d;
            hex1_q    <= hex1_d;
            hex0_q    <= hex0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign disp.bcd  = bcd_q;
    assign disp.hex2 = hex2_q;
    assign disp.hex1 = hex1_q;
    assign disp.hex0 = hex0_q;
    assign disp.busy = busy_q;
    assign disp.done = done_q;

endmodule

// File: tb/tb_count_bcd_7seg.sv
// Scoreboard bench for count_bcd_7seg: a cycle-level model of when conversions
// start pushes expected results; a negedge monitor pops them on every done.
module tb_count_bcd_7seg;

    localparam bit SEG_ACTIVE_LOW = 1'b1;
    localparam bit BLANK_LEADING  = 1'b1;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic clk50m = 1'b0;
    logic rst    = 1'b1;

    count_bcd_7seg_if bus ();

    count_bcd_7seg #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
        .BLANK_LEADING  (BLANK_LEADING)
    ) dut (
        .clk50m (clk50m),
        .rst    (rst),
        .disp   (bus.slave)
    );

    always #10 clk50m = ~clk50m;

    typedef struct {
        int unsigned value;
        int unsigned due;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned m_left = 0;
    int unsigned m_shown = 0;

    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int unsigned v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] ref_seg(input int unsigned digit, input bit blank);
        logic [6:0] c;
        c = blank ? BLANK : seg_tab[digit];
        return SEG_ACTIVE_LOW ? c : ~c;
    endfunction

    // Reference timing: a conversion starts on an idle edge seeing count != shown
    // and delivers its digits 9 edges later; reset cancels one in flight.
    always @(posedge clk50m) begin
        cyc++;
        if (rst) begin
            if (m_left != 0) void'(sb_q.pop_back());
            m_left  = 0;
            m_shown = 0;
        end else if (m_left != 0) begin
            m_left--;
            if (m_left == 0) m_shown = sb_q[$].value;
        end else if (int'(bus.count) != m_shown) begin
            sb_q.push_back('{value: int'(bus.count), due: cyc + 9});
            m_left = 9;
        end
    end

    // Monitor: busy every cycle, digits and timing on every done.
    always @(negedge clk50m) begin
        exp_t e;
        int unsigned h, t, u;
        check("busy", 32'(bus.busy), 32'(m_left != 0));
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                h = e.value / 100;
                t = (e.value / 10) % 10;
                u = e.value % 10;
                check("done_cycle", cyc, e.due);
                check("bcd", 32'(bus.bcd), 32'(ref_bcd(e.value)));
                check("hex2", 32'(bus.hex2), 32'(ref_seg(h, BLANK_LEADING && h == 0)));
                check("hex1", 32'(bus.hex1), 32'(ref_seg(t, BLANK_LEADING && h == 0 && t == 0)));
                check("hex0", 32'(bus.hex0), 32'(ref_seg(u, 1'b0)));
            end
        end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            check("done_missing", 32'd0, 32'd1);
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk50m);
            if (m_left == 0 && sb_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_bcd",  32'(bus.bcd),  32'h000);
        check("rst_hex0", 32'(bus.hex0), 32'(ref_seg(0, 1'b0)));
        check("rst_hex1", 32'(bus.hex1), 32'(ref_seg(0, BLANK_LEADING)));
        check("rst_hex2", 32'(bus.hex2), 32'(ref_seg(0, BLANK_LEADING)));
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.count = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk50m);
        check_reset_outputs();
        rst = 1'b0;
        repeat (20) @(negedge clk50m);
        check_reset_outputs();

        // Directed values: full range, non-blanked inner zero, single digit.
        bus.count = 8'd255;
        @(negedge clk50m);
        check("busy_rise", 32'(bus.busy), 32'd1);
        wait_idle();
        check("bcd_255", 32'(bus.bcd), 32'h255);
        bus.count = 8'd100;
        wait_idle();
        check("bcd_100", 32'(bus.bcd), 32'h100);
        check("hex1_100", 32'(bus.hex1), 32'(ref_seg(0, 1'b0)));

        // Change during a running conversion: old value shown, then the new one.
        bus.count = 8'd7;
        repeat (3) @(negedge clk50m);
        bus.count = 8'd42;
        wait_idle();
        check("bcd_42", 32'(bus.bcd), 32'h042);

        // Reset at E4 of a conversion of 200, then reconversion after release.
        bus.count = 8'd200;
        repeat (4) @(negedge clk50m);
        rst = 1'b1;
        @(negedge clk50m);
        check_reset_outputs();
        @(negedge clk50m);
        rst = 1'b0;
        wait_idle();
        check("bcd_200", 32'(bus.bcd), 32'h200);

        // Up-counter sweep 0..255 and wrap to 0.
        for (int v = 0; v < 257; v++) begin
            bus.count = 8'(v % 256);
            repeat (13) @(negedge clk50m);
        end
        wait_idle();
        check("wrap_bcd", 32'(bus.bcd), 32'h000);
        check("wrap_hex1", 32'(bus.hex1), 32'(ref_seg(0, BLANK_LEADING)));
        check("wrap_hex2", 32'(bus.hex2), 32'(ref_seg(0, BLANK_LEADING)));

        // Random values with random gaps, exercising coalescing.
        for (int k = 0; k < 60; k++) begin
            bus.count = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 15)) @(negedge clk50m);
        end
        wait_idle();
        check("final_shown", 32'(bus.bcd), 32'(ref_bcd(m_shown)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
